// File: rtl/grf_scoreboard.sv
// Issue-stage hazard controller for the 32x32 GRF.
// Tracks in-flight writes per register and holds issue on RAW hazards
// or when a destination's pending-write counter is full.
//
// Handshake: an instruction is accepted (issue_fire=1) in any cycle where
// issue_valid=1 and stall=0; while stall=1 upstream must hold the
// instruction unchanged. stall depends only on registered counters and the
// current issue fields, never on writeback or flush in the same cycle.
module grf_scoreboard #(
    parameter int CNT_W = 2,
    parameter int NREG  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic             issue_use_rs,
    input  logic [4:0]       issue_rs,
    input  logic             issue_use_rt,
    input  logic [4:0]       issue_rt,
    input  logic             issue_we,
    input  logic [4:0]       issue_wa,
    input  logic             wb_valid,
    input  logic [4:0]       wb_wa,
    input  logic             flush,
    output logic             stall,
    output logic             issue_fire,
    output logic [NREG-1:0]  busy_mask,
    output logic [6:0]       inflight,
    output logic             err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // cnt[0] is kept at zero so $0 never looks busy.
    logic [CNT_W-1:0] cnt [NREG];

    logic            rs_busy;
    logic            rt_busy;
    logic            wa_full;
    logic            inc;
    logic            dec;
    logic            same_reg;
    logic            dec_ok;
    logic            underflow;
    logic [NREG-1:0] inc_vec;
    logic [NREG-1:0] dec_vec;

    // Hazard detection from registered counters only.
    always_comb begin
        rs_busy    = issue_use_rs && (issue_rs != 5'd0) && (cnt[issue_rs] != '0);
        rt_busy    = issue_use_rt && (issue_rt != 5'd0) && (cnt[issue_rt] != '0);
        wa_full    = issue_we && (issue_wa != 5'd0) && (cnt[issue_wa] == CNT_MAX);
        stall      = issue_valid && (rs_busy || rt_busy || wa_full);
        issue_fire = issue_valid && !stall;
    end

    // Decode counted issue/writeback; a same-register pair cancels out.
    always_comb begin
        inc       = issue_fire && issue_we && (issue_wa != 5'd0);
        dec       = wb_valid && (wb_wa != 5'd0);
        same_reg  = inc && dec && (issue_wa == wb_wa);
        dec_ok    = dec && !same_reg && (cnt[wb_wa] != '0);
        underflow = dec && !same_reg && (cnt[wb_wa] == '0);
        inc_vec   = '0;
        dec_vec   = '0;
        if (inc && !same_reg) inc_vec[issue_wa] = 1'b1;
        if (dec_ok)           dec_vec[wb_wa]    = 1'b1;
    end

    // Counter, inflight and sticky error state; reset beats flush beats traffic.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
            inflight <= 7'd0;
            err      <= 1'b0;
        end else if (flush) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
            inflight <= 7'd0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (r == 0)          cnt[r] <= '0;
                else if (inc_vec[r]) cnt[r] <= cnt[r] + CNT_W'(1);
                else if (dec_vec[r]) cnt[r] <= cnt[r] - CNT_W'(1);
            end
            inflight <= inflight + 7'(inc && !same_reg) - 7'(dec_ok);
            if (underflow) err <= 1'b1;
        end
    end

    // Busy view of the counters; bit 0 is structurally zero.
    always_comb begin
        busy_mask = '0;
        for (int r = 1; r < NREG; r++) busy_mask[r] = (cnt[r] != '0);
    end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed plus randomized bench for grf_scoreboard with a reference model
// and an expected-state queue.
module tb_grf_scoreboard;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic        issue_use_rs;
    logic [4:0]  issue_rs;
    logic        issue_use_rt;
    logic [4:0]  issue_rt;
    logic        issue_we;
    logic [4:0]  issue_wa;
    logic        wb_valid;
    logic [4:0]  wb_wa;
    logic        flush;
    logic        stall;
    logic        issue_fire;
    logic [31:0] busy_mask;
    logic [6:0]  inflight;
    logic        err;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int   mcnt [32];
    int   minf;
    logic merr;

    logic [39:0] exp_q [$];

    grf_scoreboard #(.CNT_W(2), .NREG(32)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_use_rs(issue_use_rs), .issue_rs(issue_rs),
        .issue_use_rt(issue_use_rt), .issue_rt(issue_rt),
        .issue_we(issue_we), .issue_wa(issue_wa),
        .wb_valid(wb_valid), .wb_wa(wb_wa), .flush(flush),
        .stall(stall), .issue_fire(issue_fire), .busy_mask(busy_mask),
        .inflight(inflight), .err(err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_idle();
        reset = 0; flush = 0;
        issue_valid = 0; issue_use_rs = 0; issue_rs = 0;
        issue_use_rt = 0; issue_rt = 0; issue_we = 0; issue_wa = 0;
        wb_valid = 0; wb_wa = 0;
    endtask

    task automatic set_issue(input logic urs, input logic [4:0] rs, input logic urt,
                             input logic [4:0] rt, input logic we, input logic [4:0] wa);
        issue_valid = 1; issue_use_rs = urs; issue_rs = rs;
        issue_use_rt = urt; issue_rt = rt; issue_we = we; issue_wa = wa;
    endtask

    function automatic logic model_stall();
        logic s;
        s = 1'b0;
        if (issue_valid) begin
            if (issue_use_rs && issue_rs != 0 && mcnt[issue_rs] != 0) s = 1'b1;
            if (issue_use_rt && issue_rt != 0 && mcnt[issue_rt] != 0) s = 1'b1;
            if (issue_we && issue_wa != 0 && mcnt[issue_wa] == 3)     s = 1'b1;
        end
        return s;
    endfunction

    task automatic model_edge(input logic s);
        logic inc, dec;
        if (reset) begin
            for (int r = 0; r < 32; r++) mcnt[r] = 0;
            minf = 0; merr = 0;
        end else if (flush) begin
            for (int r = 0; r < 32; r++) mcnt[r] = 0;
            minf = 0;
        end else begin
            inc = issue_valid && !s && issue_we && issue_wa != 0;
            dec = wb_valid && wb_wa != 0;
            if (!(inc && dec && issue_wa == wb_wa)) begin
                if (inc) begin mcnt[issue_wa]++; minf++; end
                if (dec) begin
                    if (mcnt[wb_wa] == 0) merr = 1;
                    else begin mcnt[wb_wa]--; minf--; end
                end
            end
        end
    endtask

    function automatic logic [39:0] pack_model();
        logic [31:0] m;
        m = '0;
        for (int r = 1; r < 32; r++) m[r] = (mcnt[r] != 0);
        return {merr, 7'(minf), m};
    endfunction

    // One clock: check combinational outputs, advance the model, then
    // compare the registered state after the edge.
    task automatic tick();
        logic es;
        #1;
        es = model_stall();
        check("stall", 40'(stall), 40'(es));
        check("issue_fire", 40'(issue_fire), 40'(issue_valid && !es));
        model_edge(es);
        exp_q.push_back(pack_model());
        @(posedge clk);
        #1;
        check("state", {err, inflight, busy_mask}, exp_q.pop_front());
    endtask

    initial begin
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
        minf = 0; merr = 0;
        set_idle();
        reset = 1;
        @(posedge clk); #1;

        // Reset
        reset = 1; set_issue(1, 5, 1, 6, 1, 8);
        tick(); tick();
        check("rst_busy", 40'(busy_mask), 40'h0);
        check("rst_inflight", 40'(inflight), 40'h0);
        check("rst_err", 40'(err), 40'h0);

        // First write issue
        set_idle(); set_issue(1, 5, 1, 6, 1, 8);
        #1; check("t1_stall", 40'(stall), 40'h0);
        check("t1_fire", 40'(issue_fire), 40'h1);
        tick();
        check("t1_busy", 40'(busy_mask), 40'h100);
        check("t1_inflight", 40'(inflight), 40'h1);

        // RAW on $8, writeback does not clear the stall in its own cycle
        set_idle(); set_issue(1, 8, 0, 0, 0, 0);
        #1; check("t2_stall", 40'(stall), 40'h1);
        wb_valid = 1; wb_wa = 8;
        #1; check("t2_stall_wb", 40'(stall), 40'h1);
        tick();
        wb_valid = 0;
        #1; check("t2_stall_after", 40'(stall), 40'h0);
        check("t2_busy", 40'(busy_mask), 40'h0);
        check("t2_inflight", 40'(inflight), 40'h0);
        tick();

        // Saturate $9
        set_idle(); set_issue(0, 0, 0, 0, 1, 9);
        tick(); tick(); tick();
        #1; check("t3_stall_full", 40'(stall), 40'h1);
        wb_valid = 1; wb_wa = 9;
        #1; check("t3_stall_wb", 40'(stall), 40'h1);
        tick();
        wb_valid = 0;
        #1; check("t3_fire", 40'(issue_fire), 40'h1);
        tick();
        check("t3_inflight", 40'(inflight), 40'd3);

        // Same-cycle issue and writeback on $10
        set_idle(); set_issue(0, 0, 0, 0, 1, 10);
        tick();
        wb_valid = 1; wb_wa = 10;
        tick();
        check("t4_inflight", 40'(inflight), 40'd4);
        check("t4_busy10", 40'(busy_mask[10]), 40'h1);
        check("t4_err", 40'(err), 40'h0);

        // Underflow on $12, err survives flush
        set_idle(); wb_valid = 1; wb_wa = 12;
        tick();
        check("t5_err", 40'(err), 40'h1);
        check("t5_busy12", 40'(busy_mask[12]), 40'h0);
        set_idle(); flush = 1;
        tick();
        check("t5_err_flush", 40'(err), 40'h1);

        // $0 has no effect; flush discards a concurrent issue
        set_idle(); set_issue(0, 0, 0, 0, 1, 0); wb_valid = 1; wb_wa = 0;
        tick();
        check("t6_zero_infl", 40'(inflight), 40'h0);
        set_idle(); set_issue(0, 0, 0, 0, 1, 7);
        tick();
        flush = 1; set_issue(0, 0, 0, 0, 1, 3);
        tick();
        check("t6_flush_busy", 40'(busy_mask), 40'h0);
        check("t6_flush_infl", 40'(inflight), 40'h0);

        // Reset mid-stall
        set_idle(); set_issue(0, 0, 0, 0, 1, 4);
        tick();
        set_issue(1, 4, 0, 0, 0, 0);
        #1; check("t7_stall", 40'(stall), 40'h1);
        reset = 1;
        tick();
        reset = 0;
        #1; check("t7_stall_after", 40'(stall), 40'h0);
        check("t7_err_clr", 40'(err), 40'h0);
        tick();

        // Random traffic on a small register window
        for (int i = 0; i < 400; i++) begin
            set_idle();
            flush        = ($urandom_range(0, 40) == 0);
            issue_valid  = ($urandom_range(0, 3) != 0);
            issue_use_rs = $urandom_range(0, 1);
            issue_rs     = 5'($urandom_range(0, 7));
            issue_use_rt = $urandom_range(0, 1);
            issue_rt     = 5'($urandom_range(0, 7));
            issue_we     = $urandom_range(0, 1);
            issue_wa     = 5'($urandom_range(0, 7));
            wb_wa        = 5'($urandom_range(0, 7));
            wb_valid     = $urandom_range(0, 1);
            if (mcnt[wb_wa] == 0 && $urandom_range(0, 15) != 0) wb_valid = 0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
